// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// This file holds the widths, the FSM state encoding and the side encoding for last_grant.
package mem_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W = 6;
   localparam int unsigned BLOCK_W    = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } arb_side_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an instruction port and a data port sharing one block memory.
// The memory-side outputs and the returned read data are registered.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  i_read,
   input  logic [MEM_ADDR_W-1:0] i_address,
   output logic [BLOCK_W-1:0]    i_readdata,
   output logic                  i_busywait,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [MEM_ADDR_W-1:0] d_address,
   input  logic [BLOCK_W-1:0]    d_writedata,
   output logic [BLOCK_W-1:0]    d_readdata,
   output logic                  d_busywait,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [MEM_ADDR_W-1:0] mem_address,
   output logic [BLOCK_W-1:0]    mem_writedata,
   input  logic [BLOCK_W-1:0]    mem_readdata,
   input  logic                  mem_busywait
);

   arb_state_e            state_q, state_d;
   arb_side_e             last_grant_q, last_grant_d;
   logic                  busy_seen_q, busy_seen_d;
   logic                  done_i_q, done_i_d;
   logic                  done_d_q, done_d_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [MEM_ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [BLOCK_W-1:0]    mem_writedata_q, mem_writedata_d;
   logic [BLOCK_W-1:0]    i_readdata_q, i_readdata_d;
   logic [BLOCK_W-1:0]    d_readdata_q, d_readdata_d;

   logic d_req;
   logic i_elig;
   logic d_elig;

   assign d_req  = d_read | d_write;
   assign i_elig = i_read & ~done_i_q;
   assign d_elig = d_req & ~done_d_q;

   // A side stays stalled until its own completion cycle, so it drops for exactly that one cycle.
   assign i_busywait = i_elig;
   assign d_busywait = d_elig;

   assign i_readdata    = i_readdata_q;
   assign d_readdata    = d_readdata_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_address   = mem_address_q;
   assign mem_writedata = mem_writedata_q;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q         <= IDLE;
         last_grant_q    <= SIDE_I;
         busy_seen_q     <= 1'b0;
         done_i_q        <= 1'b0;
         done_d_q        <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         i_readdata_q    <= '0;
         d_readdata_q    <= '0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         busy_seen_q     <= busy_seen_d;
         done_i_q        <= done_i_d;
         done_d_q        <= done_d_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         mem_address_q   <= mem_address_d;
         mem_writedata_q <= mem_writedata_d;
         i_readdata_q    <= i_readdata_d;
         d_readdata_q    <= d_readdata_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      busy_seen_d     = busy_seen_q;
      done_i_d        = 1'b0;
      done_d_d        = 1'b0;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      mem_address_d   = mem_address_q;
      mem_writedata_d = mem_writedata_q;
      i_readdata_d    = i_readdata_q;
      d_readdata_d    = d_readdata_q;

      unique case (state_q)
         IDLE: begin
            // On a tie, the side that did not win last time gets the port.
            if (i_elig && (!d_elig || last_grant_q == SIDE_D)) begin
               state_d       = GRANT_I;
               busy_seen_d   = 1'b0;
               mem_read_d    = 1'b1;
               mem_write_d   = 1'b0;
               mem_address_d = i_address;
            end else if (d_elig) begin
               state_d         = GRANT_D;
               busy_seen_d     = 1'b0;
               mem_read_d      = ~d_write;
               mem_write_d     = d_write;
               mem_address_d   = d_address;
               mem_writedata_d = d_writedata;
            end
         end
         GRANT_I, GRANT_D: begin
            if (mem_busywait) begin
               busy_seen_d = 1'b1;
            end else if (busy_seen_q) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (state_q == GRANT_I) begin
                  i_readdata_d = mem_readdata;
                  done_i_d     = 1'b1;
                  last_grant_d = SIDE_I;
               end else begin
                  if (mem_read_q) begin
                     d_readdata_d = mem_readdata;
                  end
                  done_d_d     = 1'b1;
                  last_grant_d = SIDE_D;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench drives the memory handshake by hand and checks outputs on falling edges.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        i_read;
   logic [5:0]  i_address;
   logic [31:0] i_readdata;
   logic        i_busywait;
   logic        d_read;
   logic        d_write;
   logic [5:0]  d_address;
   logic [31:0] d_writedata;
   logic [31:0] d_readdata;
   logic        d_busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   int tests = 0;
   int fails = 0;

   mem_arbiter dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_readdata   (i_readdata),
      .i_busywait   (i_busywait),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_writedata  (d_writedata),
      .d_readdata   (d_readdata),
      .d_busywait   (d_busywait),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_writedata(mem_writedata),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      RESET        = 1'b0;
      i_read       = 1'b1;
      d_read       = 1'b1;
      d_write      = 1'b1;
      i_address    = 6'h2A;
      d_address    = 6'h15;
      d_writedata  = 32'hFFFF0000;
      mem_busywait = 1'b0;
      mem_readdata = 32'h0;

      // Reset held with every request high.
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         chk("rst_mem_read", mem_read, 0);
         chk("rst_mem_write", mem_write, 0);
         chk("rst_mem_address", mem_address, 0);
         chk("rst_mem_writedata", mem_writedata, 0);
         chk("rst_i_readdata", i_readdata, 0);
         chk("rst_d_readdata", d_readdata, 0);
         chk("rst_i_busywait", i_busywait, 1);
         chk("rst_d_busywait", d_busywait, 1);
      end
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      RESET   = 1'b1;
      @(negedge CLK);
      chk("idle_mem_read", mem_read, 0);

      // Simultaneous requests: data side wins the first tie.
      i_read = 1'b1; i_address = 6'h01;
      d_read = 1'b1; d_address = 6'h02;
      @(negedge CLK);
      chk("tie_first_addr", mem_address, 6'h02);
      chk("tie_first_read", mem_read, 1);
      chk("tie_first_write", mem_write, 0);
      chk("tie_i_bw", i_busywait, 1);
      chk("tie_d_bw", d_busywait, 1);
      mem_busywait = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         chk("tie_i_bw_hold", i_busywait, 1);
         chk("tie_addr_hold", mem_address, 6'h02);
      end
      mem_busywait = 1'b0; mem_readdata = 32'hCAFE0002;
      @(negedge CLK);
      chk("tie_d_done_bw", d_busywait, 0);
      chk("tie_d_readdata", d_readdata, 32'hCAFE0002);
      chk("tie_d_mem_read_clr", mem_read, 0);
      chk("tie_i_bw_still", i_busywait, 1);
      d_read = 1'b0;
      @(negedge CLK);
      chk("tie_second_addr", mem_address, 6'h01);
      chk("tie_second_read", mem_read, 1);
      mem_busywait = 1'b1;
      @(negedge CLK);
      mem_busywait = 1'b0; mem_readdata = 32'h11110001;
      @(negedge CLK);
      chk("tie_i_readdata", i_readdata, 32'h11110001);
      chk("tie_i_done_bw", i_busywait, 0);
      chk("tie_d_readdata_keep", d_readdata, 32'hCAFE0002);
      i_read = 1'b0;
      mem_readdata = 32'h0;
      @(negedge CLK);

      // Instruction read with a 5-cycle busy memory; address change mid-transaction is ignored.
      i_read = 1'b1; i_address = 6'h05;
      @(negedge CLK);
      chk("ird_mem_read", mem_read, 1);
      chk("ird_mem_address", mem_address, 6'h05);
      chk("ird_i_bw", i_busywait, 1);
      mem_busywait = 1'b1;
      i_address    = 6'h3C;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         chk("ird_addr_latched", mem_address, 6'h05);
         chk("ird_read_hold", mem_read, 1);
         chk("ird_bw_hold", i_busywait, 1);
      end
      mem_busywait = 1'b0; mem_readdata = 32'hDEADBEEF;
      @(negedge CLK);
      chk("ird_done_bw", i_busywait, 0);
      chk("ird_readdata", i_readdata, 32'hDEADBEEF);
      chk("ird_mem_read_clr", mem_read, 0);
      mem_readdata = 32'h0;
      @(negedge CLK);
      chk("ird_bw_one_cycle", i_busywait, 1);
      chk("ird_no_regrant", mem_read, 0);
      chk("ird_readdata_hold", i_readdata, 32'hDEADBEEF);
      i_read = 1'b0;
      @(negedge CLK);

      // Data write.
      d_write = 1'b1; d_address = 6'h3F; d_writedata = 32'h12345678;
      @(negedge CLK);
      chk("dwr_mem_write", mem_write, 1);
      chk("dwr_mem_read", mem_read, 0);
      chk("dwr_mem_address", mem_address, 6'h3F);
      chk("dwr_mem_writedata", mem_writedata, 32'h12345678);
      mem_busywait = 1'b1;
      d_writedata  = 32'h0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         chk("dwr_bw_hold", d_busywait, 1);
         chk("dwr_wdata_latched", mem_writedata, 32'h12345678);
      end
      mem_busywait = 1'b0; mem_readdata = 32'h99999999;
      @(negedge CLK);
      chk("dwr_done_bw", d_busywait, 0);
      chk("dwr_mem_write_clr", mem_write, 0);
      chk("dwr_readdata_keep", d_readdata, 32'hCAFE0002);
      @(negedge CLK);
      chk("dwr_bw_one_cycle", d_busywait, 1);
      d_write = 1'b0;
      @(negedge CLK);

      // Read and write together behave as a write.
      d_read = 1'b1; d_write = 1'b1; d_address = 6'h10; d_writedata = 32'hA5A5A5A5;
      @(negedge CLK);
      chk("drw_mem_write", mem_write, 1);
      chk("drw_mem_read", mem_read, 0);
      chk("drw_mem_writedata", mem_writedata, 32'hA5A5A5A5);
      chk("drw_mem_address", mem_address, 6'h10);
      mem_busywait = 1'b1;
      @(negedge CLK);
      mem_busywait = 1'b0; mem_readdata = 32'h77777777;
      @(negedge CLK);
      chk("drw_readdata_keep", d_readdata, 32'hCAFE0002);
      chk("drw_mem_write_clr", mem_write, 0);
      chk("drw_done_bw", d_busywait, 0);
      d_read = 1'b0; d_write = 1'b0;
      @(negedge CLK);

      // Reset in the middle of a data read aborts it.
      d_read = 1'b1; d_address = 6'h22;
      @(negedge CLK);
      chk("abt_mem_read", mem_read, 1);
      mem_busywait = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      chk("abt_mem_read_clr", mem_read, 0);
      chk("abt_mem_address", mem_address, 0);
      chk("abt_d_readdata", d_readdata, 0);
      chk("abt_i_readdata", i_readdata, 0);
      chk("abt_d_bw", d_busywait, 1);
      RESET = 1'b1; d_read = 1'b0;
      mem_busywait = 1'b0; mem_readdata = 32'hBAD0BAD0;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         chk("abt_no_update", d_readdata, 0);
         chk("abt_idle_read", mem_read, 0);
         chk("abt_idle_write", mem_write, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RESET  input  1  reset; synchronous and active-low (RESET==0 at a CLK rising edge resets the block).
REQ-003 i_read  input  1  instruction-side block read request, held until i_busywait deasserts.
REQ-004 i_address  input  6  instruction-side block address.
REQ-005 i_readdata  output  32  instruction-side returned block, registered.
REQ-006 i_busywait  output  1  instruction-side stall.
REQ-007 d_read / d_write  input  1 each  data-side block read / write requests, held until d_busywait deasserts.
REQ-008 d_address  input  6; d_writedata  input  32; d_readdata  output  32 (registered); d_busywait  output  1.
REQ-009 mem_read / mem_write  output  1 each; mem_address  output  6; mem_writedata  output  32; all registered.
REQ-010 mem_readdata  input  32; mem_busywait  input  1  shared main-memory port.

Function
REQ-011 FSM states: IDLE, GRANT_I, GRANT_D; exactly one requester owns the memory port outside IDLE.
REQ-012 IDLE arbitration at posedge: sole eligible requester is granted; if both are eligible, grant the side not equal to last_grant (round-robin).
REQ-013 A side is eligible in IDLE when its request is high and its done flag is clear.
REQ-014 On grant: latch address/writedata/op into mem_* registers; mem_read or mem_write goes high the cycle after the request is seen (1-cycle grant latency).
REQ-015 d_read and d_write both high: treated as write; d_read ignored.
REQ-016 In GRANT_x: busy_seen set at the first posedge sampling mem_busywait==1.
REQ-017 In GRANT_x: the transaction completes at the first posedge with busy_seen==1 and mem_busywait==0.
REQ-018 On completion: mem_read/mem_write cleared; for reads, x_readdata <= mem_readdata; done_x <= 1; last_grant <= x; state -> IDLE.
REQ-019 Requester input changes during GRANT_x are ignored; latched values drive memory until completion.
REQ-020 x_busywait = x request high AND done_x==0 (combinational); it therefore deasserts for exactly the one cycle done_x is high.
REQ-021 done_x clears at the next posedge unconditionally.
REQ-022 x_readdata holds its value between reads; writes never modify d_readdata.
REQ-023 The non-granted side keeps its busywait high for the whole foreign transaction.

Reset
REQ-024 At any posedge with RESET==0: state=IDLE, last_grant=I (data side wins the first tie), busy_seen=0, done_i=done_d=0.
REQ-025 Reset values: mem_read=mem_write=0, mem_address=0, mem_writedata=0, i_readdata=d_readdata=0.
REQ-026 Reset mid-transaction aborts it; a later mem_busywait fall produces no completion and no readdata update.

Structure
REQ-027 Shared package holds state encoding, MEM_ADDR_W=6, BLOCK_W=32, and side encodings I/D for last_grant.
REQ-028 Single flat module; no sub-module required (the round-robin pick stays inline).

Verification
REQ-029 RESET=0 for 2 cycles with all requests high -> all outputs 0 except busywaits=1, no mem_read/mem_write pulse.
REQ-030 i_read, i_address=6'h05; memory busy 5 cycles, then returns 32'hDEADBEEF.
- mem_read=1 and mem_address=6'h05 one cycle after the request.
- i_readdata=32'hDEADBEEF.
- i_busywait low for exactly one cycle.
REQ-031 i_read and d_read raised together after reset, addresses 6'h01/6'h02 -> mem_address sequence 6'h02 then 6'h01; i_busywait stays high through the D transaction.
REQ-032 d_write, d_address=6'h3F, d_writedata=32'h12345678 -> mem_write=1, mem_address=6'h3F, mem_writedata=32'h12345678; d_readdata unchanged; d_busywait drops one cycle.
REQ-033 RESET pulled low during GRANT_D -> next cycle mem_read=0 and state IDLE; a subsequent mem_busywait fall leaves d_readdata=0.
REQ-034 d_read=d_write=1 with d_writedata=32'hA5A5A5A5 -> only mem_write asserted, data 32'hA5A5A5A5.
